// File: rtl/modexp_sequencer_if.sv
// Bus between the modexp sequencer and the Montgomery multiply slave.
// The master drives the operands and the run/load enable; the slave answers with endflag and answer.
interface modexp_sequencer_if #(
    parameter int WIDTH = 256
);
    logic             slv_en;
    logic [WIDTH-1:0] slv_multiplicand;
    logic [WIDTH-1:0] slv_indata;
    logic             slv_pow_bit;
    logic             slv_endflag;
    logic [WIDTH-1:0] slv_answer;

    modport master (
        output slv_en, slv_multiplicand, slv_indata, slv_pow_bit,
        input  slv_endflag, slv_answer
    );

    modport slave (
        input  slv_en, slv_multiplicand, slv_indata, slv_pow_bit,
        output slv_endflag, slv_answer
    );
endinterface

// File: rtl/modexp_sequencer.sv
// Left-to-right square-and-multiply modular exponentiation controller.
// It issues one Montgomery slave pass per exponent bit, MSB first, and returns the accumulator.
//
// state  | meaning
// IDLE   | waiting for start; outputs held
// LOAD   | slave en=0, slave latches acc / base / current exponent MSB
// RUN    | slave en=1, waiting for endflag under the watchdog
// DONE   | publish acc to result, pulse done
module modexp_sequencer #(
    parameter int WIDTH   = 256,
    parameter int EBITS   = 256,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [EBITS-1:0]    exponent,
    input  logic [WIDTH-1:0]    base_mont,
    input  logic [WIDTH-1:0]    one_mont,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [WIDTH-1:0]    result,
    modexp_sequencer_if.master  slv
);
    localparam int CW = $clog2(EBITS + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [EBITS-1:0] exp_reg;
    logic [WIDTH-1:0] base_reg;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    bitcnt;
    logic [WW-1:0]    wdog;
    logic             en_q;

    // Slave operands come straight from the working registers, so they are stable through a pass.
    assign slv.slv_en           = en_q;
    assign slv.slv_multiplicand = acc;
    assign slv.slv_indata       = base_reg;
    assign slv.slv_pow_bit      = exp_reg[EBITS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            exp_reg  <= '0;
            base_reg <= '0;
            acc      <= '0;
            bitcnt   <= '0;
            wdog     <= '0;
            en_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            result   <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc  <= one_mont;
                        busy <= 1'b1;
                        if (exponent != '0) begin
                            exp_reg  <= exponent;
                            base_reg <= base_mont;
                            bitcnt   <= CW'(EBITS);
                            state    <= S_LOAD;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_LOAD: begin
                    wdog  <= WW'(TIMEOUT - 1);
                    en_q  <= 1'b1;
                    state <= S_RUN;
                end
                S_RUN: begin
                    // endflag is checked first so it wins over a coincident timeout
                    if (slv.slv_endflag) begin
                        acc     <= slv.slv_answer;
                        exp_reg <= exp_reg << 1;
                        bitcnt  <= bitcnt - 1'b1;
                        en_q    <= 1'b0;
                        state   <= (bitcnt == CW'(1)) ? S_DONE : S_LOAD;
                    end else if (wdog == '0) begin
                        error <= 1'b1;
                        en_q  <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        wdog <= wdog - 1'b1;
                    end
                end
                S_DONE: begin
                    result <= acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_modexp_sequencer.sv
// Bench for modexp_sequencer: behavioural Montgomery slave, plain modular-exponent reference,
// a table of fixed and random vectors, plus hand sequences for start-while-busy, timeout and reset.
module tb_modexp_sequencer;
    localparam int WIDTH   = 16;
    localparam int EBITS   = 4;
    localparam int TIMEOUT = 64;
    localparam int M       = 97;
    localparam int R       = 256;
    localparam int L1      = 17;
    localparam int L0      = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [EBITS-1:0] exponent = '0;
    logic [WIDTH-1:0] base_mont = '0;
    logic [WIDTH-1:0] one_mont = '0;
    logic             busy, done, error;
    logic [WIDTH-1:0] result;

    modexp_sequencer_if #(.WIDTH(WIDTH)) slv ();

    modexp_sequencer #(.WIDTH(WIDTH), .EBITS(EBITS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .exponent(exponent),
        .base_mont(base_mont), .one_mont(one_mont), .busy(busy), .done(done),
        .error(error), .result(result), .slv(slv)
    );

    always #5 clk = ~clk;

    int     n_vec = 0;
    int     n_err = 0;
    longint rinv = 0;
    bit     slave_dead = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint mont(longint x, longint y);
        return ((x * y) % M) * rinv % M;
    endfunction

    function automatic longint slave_pass(longint a, longint b, bit p);
        longint s;
        s = mont(a, a);
        return p ? mont(s, b) : s;
    endfunction

    // Reference: Montgomery form of b^e, computed with plain modular arithmetic.
    function automatic longint ref_exp(int b, int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % M;
        return (r * R) % M;
    endfunction

    function automatic int ref_lat(logic [EBITS-1:0] e);
        int l;
        if (e == '0) return 2;
        l = 2;
        for (int i = 0; i < EBITS; i++) l += 1 + (e[i] ? L1 : L0);
        return l;
    endfunction

    // Behavioural slave: latches operands while en=0, raises endflag in the L-th run cycle.
    int               scnt;
    logic [WIDTH-1:0] op_a, op_b;
    logic             op_p;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt <= 0;
            slv.slv_endflag <= 1'b0;
            slv.slv_answer <= '0;
            op_a <= '0;
            op_b <= '0;
            op_p <= 1'b0;
        end else if (!slv.slv_en) begin
            scnt <= 0;
            slv.slv_endflag <= 1'b0;
            op_a <= slv.slv_multiplicand;
            op_b <= slv.slv_indata;
            op_p <= slv.slv_pow_bit;
        end else begin
            scnt <= scnt + 1;
            if (!slave_dead && scnt == (op_p ? L1 : L0) - 2) begin
                slv.slv_endflag <= 1'b1;
                slv.slv_answer <= WIDTH'(slave_pass(longint'(op_a), longint'(op_b), op_p));
            end else begin
                slv.slv_endflag <= 1'b0;
            end
        end
    end

    task automatic run_op(input logic [EBITS-1:0] e, input int b, input int inject_at, input int post,
                          output int lat, output logic [WIDTH-1:0] res, output int loads,
                          output logic [EBITS-1:0] seq, output int dones, output int errs,
                          output int unstable, output logic busy1, output logic busy_end);
        int   t;
        logic prev_en, pb;
        @(negedge clk);
        exponent = e; base_mont = WIDTH'((b * R) % M); one_mont = WIDTH'(R % M); start = 1'b1;
        lat = -1; res = '0; loads = 0; seq = '0; dones = 0; errs = 0; unstable = 0;
        busy1 = 1'b0; busy_end = 1'b1; prev_en = 1'b0; pb = 1'b0; t = 0;
        while (t < 2000 && (lat < 0 || t < lat + post)) begin
            @(negedge clk);
            t++;
            if (t == 1) begin
                start = 1'b0;
                exponent = EBITS'($urandom); base_mont = WIDTH'($urandom); one_mont = WIDTH'($urandom);
                busy1 = busy;
            end
            if (t == inject_at) begin
                start = 1'b1; exponent = ~e; base_mont = WIDTH'($urandom_range(1, M - 1));
            end else if (t == inject_at + 1) begin
                start = 1'b0;
            end
            if (slv.slv_en && !prev_en) begin
                loads++;
                seq = {seq[EBITS-2:0], slv.slv_pow_bit};
                pb = slv.slv_pow_bit;
            end
            if (slv.slv_en && slv.slv_pow_bit !== pb) unstable++;
            prev_en = slv.slv_en;
            if (error) errs++;
            if (done) begin
                dones++;
                if (lat < 0) begin
                    lat = t; res = result; busy_end = busy;
                end
            end
        end
    endtask

    typedef struct {
        logic [EBITS-1:0] e;
        int               b;
        longint           exp_res;
        int               exp_lat;
    } vec_t;

    initial begin
        vec_t             vecs[$];
        int               lat, loads, dones, errs, unstable, t, tr, te;
        logic [WIDTH-1:0] res, res_at, last_res;
        logic [EBITS-1:0] seq;
        logic             busy1, busy_end, en_at, busy_at;
        logic [EBITS-1:0] fe[6] = '{4'b1011, 4'b0000, 4'b0001, 4'b1111, 4'b1000, 4'b0110};
        int               fb[6] = '{5, 7, 3, 2, 10, 96};

        for (int i = 1; i < M; i++) if ((R * i) % M == 1) rinv = i;
        for (int i = 0; i < 6; i++) vecs.push_back('{fe[i], fb[i], ref_exp(fb[i], int'(fe[i])), ref_lat(fe[i])});
        for (int i = 0; i < 6; i++) begin
            logic [EBITS-1:0] re;
            int               rb;
            re = EBITS'($urandom_range(0, 15));
            rb = $urandom_range(1, M - 1);
            vecs.push_back('{re, rb, ref_exp(rb, int'(re)), ref_lat(re)});
        end

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_result", result, 0);
        check("rst_slv_en", slv.slv_en, 0);
        check("rst_pow_bit", slv.slv_pow_bit, 0);
        check("rst_multiplicand", slv.slv_multiplicand, 0);
        check("rst_indata", slv.slv_indata, 0);
        rst_n = 1'b1;

        last_res = '0;
        foreach (vecs[i]) begin
            run_op(vecs[i].e, vecs[i].b, 0, 5, lat, res, loads, seq, dones, errs, unstable, busy1, busy_end);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("v%0d_loads", i), loads, (vecs[i].e == '0) ? 0 : EBITS);
            check($sformatf("v%0d_pow_seq", i), seq, vecs[i].e);
            check($sformatf("v%0d_dones", i), dones, 1);
            check($sformatf("v%0d_errors", i), errs, 0);
            check($sformatf("v%0d_pow_unstable", i), unstable, 0);
            check($sformatf("v%0d_busy_after_start", i), busy1, 1);
            check($sformatf("v%0d_busy_at_done", i), busy_end, 0);
            last_res = WIDTH'(vecs[i].exp_res);
        end

        // start pulsed during RUN of the first pass must be ignored
        run_op(4'b1011, 5, 10, 80, lat, res, loads, seq, dones, errs, unstable, busy1, busy_end);
        check("busy_start_latency", lat, 66);
        check("busy_start_result", res, ref_exp(5, 11));
        check("busy_start_dones", dones, 1);
        check("busy_start_loads", loads, EBITS);
        last_res = WIDTH'(ref_exp(5, 11));

        // slave never answers: watchdog fires TIMEOUT cycles into RUN
        slave_dead = 1'b1;
        @(negedge clk);
        exponent = 4'b1011; base_mont = WIDTH'((6 * R) % M); one_mont = WIDTH'(R % M); start = 1'b1;
        t = 0; tr = -1; te = -1; en_at = 1'b1; busy_at = 1'b1; res_at = '0;
        while (t < 400 && te < 0) begin
            @(negedge clk);
            t++;
            if (t == 1) start = 1'b0;
            if (slv.slv_en && tr < 0) tr = t;
            if (error) begin
                te = t; en_at = slv.slv_en; busy_at = busy; res_at = result;
            end
        end
        check("timeout_run_start", tr, 2);
        check("timeout_cycles", te - tr, TIMEOUT);
        check("timeout_slv_en", en_at, 0);
        check("timeout_busy", busy_at, 0);
        check("timeout_result_kept", res_at, last_res);
        @(negedge clk);
        check("timeout_error_pulse", error, 0);
        check("timeout_no_done", done, 0);
        slave_dead = 1'b0;

        // reset during the third pass
        @(negedge clk);
        exponent = 4'b1011; base_mont = WIDTH'((6 * R) % M); one_mont = WIDTH'(R % M); start = 1'b1;
        t = 0; loads = 0; en_at = 1'b0;
        while (t < 400 && loads < 3) begin
            @(negedge clk);
            t++;
            if (t == 1) start = 1'b0;
            if (slv.slv_en && !en_at) loads++;
            en_at = slv.slv_en;
        end
        check("reset_reached_pass3", loads, 3);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_error", error, 0);
        check("midrst_result", result, 0);
        check("midrst_slv_en", slv.slv_en, 0);
        check("midrst_pow_bit", slv.slv_pow_bit, 0);
        check("midrst_multiplicand", slv.slv_multiplicand, 0);
        check("midrst_indata", slv.slv_indata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(4'b0001, 6, 0, 5, lat, res, loads, seq, dones, errs, unstable, busy1, busy_end);
        check("post_rst_latency", lat, ref_lat(4'b0001));
        check("post_rst_result", res, ref_exp(6, 1));
        check("post_rst_dones", dones, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
